dpu_pipe: RTL

Parametrised successor to the 4-bit combinational datapath unit. Operand width is generic, and the block adds a registered result stage, valid/ready handshakes on both sides, an iterative multiplier FSM and an internal destination register file. It sits between the instruction sequencer and the pixel/ALU consumers of the graphics pipeline. Condition codes are registered together with the result.

---
 rtl/dpu_pkg.sv | 18 +
 rtl/dpu_mul_iter.sv | 42 ++++
 rtl/dpu_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dpu_pkg.sv
// dpu_pkg: opcodes, FSM state codes and condition-code bit positions shared by dpu_pipe.
package dpu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;
endpackage

// File: rtl/dpu_mul_iter.sv
// dpu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle, DATA_W cycles per product.
module dpu_mul_iter #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] prod
);
  localparam int CNT_W = $clog2(DATA_W);
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  always_comb begin
    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    busy_d   = start || (busy_q && !done);
    cnt_d    = start ? '0 : (busy_q ? cnt_q + CNT_W'(1) : cnt_q);
    mcand_d  = start ? {{DATA_W{1'b0}}, a} : (busy_q ? mcand_q << 1 : mcand_q);
    mplier_d = start ? b : (busy_q ? mplier_q >> 1 : mplier_q);
    acc_d    = start ? '0 : (busy_q ? prod : acc_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: rtl/dpu_pipe.sv
// dpu_pipe: registered datapath unit with valid/ready handshakes, iterative MUL and destination register file.
// Define DPU_SAT_EN for saturating ADD/SUB; otherwise ADD/SUB wrap.
module dpu_pipe
  import dpu_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 3,
  localparam int RIDX_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a_bus,
  input  logic [DATA_W-1:0]   b_bus,
  input  logic [RIDX_W-1:0]   r_bus,
  input  logic [OP_W-1:0]     n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] k,
  output logic [3:0]          cc,
  input  logic [RIDX_W-1:0]   rf_rd_addr,
  output logic [DATA_W-1:0]   rf_rd_data
);
  localparam int SH_W = $clog2(DATA_W);
  logic [1:0]          st_q, st_d;
  logic [2*DATA_W-1:0] k_q, k_d;
  logic [3:0]          cc_q, cc_d;
  logic [RIDX_W-1:0]   r_q, r_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   rf_d [NUM_REGS];
  logic                accept, is_mul, mul_done, c, v;
  logic [2*DATA_W-1:0] mul_prod;
  logic [DATA_W:0]     sum, dif, shl_x, shr_x;
  logic [DATA_W-1:0]   res;
  logic [SH_W-1:0]     amt;

  dpu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(accept && is_mul),
    .a    (a_bus),
    .b    (b_bus),
    .done (mul_done),
    .prod (mul_prod)
  );

  // Single-cycle ops are evaluated straight off the input bus and registered at acceptance.
  always_comb begin
    amt   = b_bus[SH_W-1:0];
    sum   = {1'b0, a_bus} + {1'b0, b_bus};
    dif   = {1'b0, a_bus} - {1'b0, b_bus};
    shl_x = {1'b0, a_bus} << amt;
    shr_x = {a_bus, 1'b0} >> amt;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (n)
      OP_ADD: begin
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_bus[DATA_W-1] == b_bus[DATA_W-1]) && (sum[DATA_W-1] != a_bus[DATA_W-1]);
      end
      OP_SUB: begin
        res = dif[DATA_W-1:0];
        c   = dif[DATA_W];
        v   = (a_bus[DATA_W-1] != b_bus[DATA_W-1]) && (dif[DATA_W-1] != a_bus[DATA_W-1]);
      end
      OP_AND: res = a_bus & b_bus;
      OP_OR:  res = a_bus | b_bus;
      OP_XOR: res = a_bus ^ b_bus;
      OP_SHL: begin
        res = shl_x[DATA_W-1:0];
        c   = shl_x[DATA_W];
      end
      OP_SHR: begin
        res = shr_x[DATA_W:1];
        c   = shr_x[0];
      end
      default: ;
    endcase
`ifdef DPU_SAT_EN
    if (n == OP_ADD || n == OP_SUB) begin
      res = c ? ((n == OP_ADD) ? '1 : '0) : res;
      v   = 1'b0;
    end
`endif
  end

  always_comb begin
    in_ready  = (st_q == ST_IDLE) || (st_q == ST_DONE && out_ready);
    out_valid = (st_q == ST_DONE);
    accept    = in_valid && in_ready;
    is_mul    = (n == OP_MUL);
    st_d      = st_q;
    k_d       = k_q;
    cc_d      = cc_q;
    r_d       = r_q;
    rf_d      = rf_q;
    if (st_q == ST_DONE && out_ready) st_d = ST_IDLE;
    if (accept) begin
      r_d  = r_bus;
      st_d = is_mul ? ST_MUL : ST_DONE;
      if (!is_mul) begin
        k_d         = {{DATA_W{1'b0}}, res};
        cc_d[CC_N]  = res[DATA_W-1];
        cc_d[CC_Z]  = (res == '0);
        cc_d[CC_C]  = c;
        cc_d[CC_V]  = v;
        rf_d[r_bus] = res;
      end
    end
    if (st_q == ST_MUL && mul_done) begin
      st_d       = ST_DONE;
      k_d        = mul_prod;
      cc_d[CC_N] = mul_prod[2*DATA_W-1];
      cc_d[CC_Z] = (mul_prod == '0);
      cc_d[CC_C] = 1'b0;
      cc_d[CC_V] = 1'b0;
      rf_d[r_q]  = mul_prod[DATA_W-1:0];
    end
    k          = k_q;
    cc         = cc_q;
    rf_rd_data = rf_q[rf_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;
      k_q  <= '0;
      cc_q <= '0;
      r_q  <= '0;
      rf_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      k_q  <= k_d;
      cc_q <= cc_d;
      r_q  <= r_d;
      rf_q <= rf_d;
    end
  end
endmodule
